fifo_sync_umbral: RTL and testbench

//  Parametrised single-clock synchronous FIFO; next generation of the team's flow-control FIFO.

---
 rtl/fifo_sync_umbral.sv | 94 +++++++++
 tb/tb_fifo_sync_umbral.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/fifo_sync_umbral.sv
// Single-clock FIFO with programmable almost-full/almost-empty thresholds, occupancy count and error flags.
// Latency: a pop registers data_out/valid_out one cycle after it is accepted; flags decode the registered count.
// Backpressure: pushes are refused when full unless a pop is accepted that cycle; refused requests raise errors.
// Optional macro FIFO_STICKY_ERROR_EN: error flags latch until reset instead of pulsing.
module fifo_sync_umbral #(
  parameter int DW = 8,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] data_in,
  input  logic [AW:0]   umbral_almost_full,
  input  logic [AW:0]   umbral_almost_empty,
  output logic [DW-1:0] data_out,
  output logic          valid_out,
  output logic [AW:0]   count,
  output logic          fifo_full,
  output logic          fifo_empty,
  output logic          almost_full,
  output logic          almost_empty,
  output logic          error_overflow,
  output logic          error_underflow,
  output logic          error
);

  localparam logic [AW:0]   DEPTH   = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          pop_ok;
  logic          push_ok;
  logic          ovf_evt;
  logic          unf_evt;

  // Status decodes of the registered occupancy and the live thresholds
  assign fifo_full    = (count == DEPTH);
  assign fifo_empty   = (count == '0);
  assign almost_full  = (umbral_almost_full != '0) && (count >= umbral_almost_full);
  assign almost_empty = (count <= umbral_almost_empty);
  assign error        = error_overflow | error_underflow;

  // A pop frees a slot in the same cycle, so a full FIFO can still take a push alongside it
  assign pop_ok  = pop && !fifo_empty;
  assign push_ok = push && (!fifo_full || pop_ok);
  assign ovf_evt = push && !push_ok;
  assign unf_evt = pop && fifo_empty;

  // Storage array: not reset, writes suppressed while reset is asserted
  always_ff @(posedge clk) begin
    if (!reset && push_ok) begin
      mem[wr_ptr] <= data_in;
    end
  end

  // Pointers, occupancy, read register and error flags
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      count           <= '0;
      data_out        <= '0;
      valid_out       <= 1'b0;
      error_overflow  <= 1'b0;
      error_underflow <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop_ok) begin
        rd_ptr   <= rd_ptr + PTR_ONE;
        data_out <= mem[rd_ptr];
      end
      valid_out <= pop_ok;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
`ifdef FIFO_STICKY_ERROR_EN
      error_overflow  <= error_overflow | ovf_evt;
      error_underflow <= error_underflow | unf_evt;
`else
      error_overflow  <= ovf_evt;
      error_underflow <= unf_evt;
`endif
    end
  end

endmodule

// File: tb/tb_fifo_sync_umbral.sv
module tb_fifo_sync_umbral;

  localparam int DW = 8;
  localparam int AW = 3;
  localparam int DEPTH = 8;
`ifdef FIFO_STICKY_ERROR_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic          clk;
  logic          reset;
  logic          push;
  logic          pop;
  logic [DW-1:0] data_in;
  logic [AW:0]   umbral_almost_full;
  logic [AW:0]   umbral_almost_empty;
  logic [DW-1:0] data_out;
  logic          valid_out;
  logic [AW:0]   count;
  logic          fifo_full;
  logic          fifo_empty;
  logic          almost_full;
  logic          almost_empty;
  logic          error_overflow;
  logic          error_underflow;
  logic          error;

  fifo_sync_umbral #(.DW(DW), .AW(AW)) dut (
    .clk                 (clk),
    .reset               (reset),
    .push                (push),
    .pop                 (pop),
    .data_in             (data_in),
    .umbral_almost_full  (umbral_almost_full),
    .umbral_almost_empty (umbral_almost_empty),
    .data_out            (data_out),
    .valid_out           (valid_out),
    .count               (count),
    .fifo_full           (fifo_full),
    .fifo_empty          (fifo_empty),
    .almost_full         (almost_full),
    .almost_empty        (almost_empty),
    .error_overflow      (error_overflow),
    .error_underflow     (error_underflow),
    .error               (error)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: FIFO contents as a queue, expected read data in a scoreboard
  logic [DW-1:0] mq[$];
  logic [DW-1:0] sb[$];
  int  exp_dout;
  bit  exp_valid;
  bit  exp_ovf;
  bit  exp_unf;
  bit  mon_en;
  int  total;
  int  passed;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor: every presented word must be the oldest outstanding expected word
  always @(negedge clk) begin
    if (mon_en && valid_out === 1'b1) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_valid", 1, 0);
      end else begin
        chk("sb_read_data", int'(data_out), int'(sb.pop_front()));
      end
    end
  end

  task automatic step(input bit p, input bit q, input logic [DW-1:0] d, input bit r);
    int  sz;
    bit  pop_ok;
    bit  push_ok;
    int  af;
    int  ae;
    push = p; pop = q; data_in = d; reset = r;
    @(posedge clk);
    sz = mq.size();
    if (r) begin
      mq.delete();
      exp_dout = 0; exp_valid = 0; exp_ovf = 0; exp_unf = 0;
    end else begin
      pop_ok  = q && (sz > 0);
      push_ok = p && ((sz < DEPTH) || pop_ok);
      if (pop_ok) begin
        exp_dout = int'(mq.pop_front());
        sb.push_back(exp_dout[DW-1:0]);
      end
      if (push_ok) mq.push_back(d);
      exp_valid = pop_ok;
      exp_ovf = (STICKY && exp_ovf) || (p && !push_ok);
      exp_unf = (STICKY && exp_unf) || (q && sz == 0);
    end
    @(negedge clk);
    sz = mq.size();
    af = int'(umbral_almost_full);
    ae = int'(umbral_almost_empty);
    chk("count", int'(count), sz);
    chk("fifo_full", int'(fifo_full), int'(sz == DEPTH));
    chk("fifo_empty", int'(fifo_empty), int'(sz == 0));
    chk("almost_full", int'(almost_full), int'(af != 0 && sz >= af));
    chk("almost_empty", int'(almost_empty), int'(sz <= ae));
    chk("valid_out", int'(valid_out), int'(exp_valid));
    chk("data_out", int'(data_out), exp_dout);
    chk("error_overflow", int'(error_overflow), int'(exp_ovf));
    chk("error_underflow", int'(error_underflow), int'(exp_unf));
    chk("error", int'(error), int'(exp_ovf || exp_unf));
  endtask

  initial begin
    bit p;
    bit q;
    int pp;
    int qp;
    total = 0; passed = 0; mon_en = 0;
    exp_dout = 0; exp_valid = 0; exp_ovf = 0; exp_unf = 0;
    push = 0; pop = 0; data_in = '0; reset = 1;
    umbral_almost_full = 4'd6; umbral_almost_empty = 4'd2;

    // Reset for two cycles
    step(0, 0, 8'h00, 1);
    step(0, 0, 8'h00, 1);
    mon_en = 1;

    // Three pushes then one pop
    step(1, 0, 8'hE1, 0);
    step(1, 0, 8'hE2, 0);
    step(1, 0, 8'hE3, 0);
    step(0, 1, 8'h00, 0);
    chk("first_pop_data", int'(data_out), 8'hE1);
    step(0, 0, 8'h00, 1);

    // Fill from empty, then overflow attempt, then drain in order
    for (int i = 0; i < DEPTH; i++) step(1, 0, 8'h10 + 8'(i), 0);
    step(1, 0, 8'hFF, 0);
    chk("overflow_pulse", int'(error_overflow), 1);
    for (int i = 0; i < DEPTH; i++) step(0, 1, 8'h00, 0);

    // Underflow on empty
    step(0, 1, 8'h00, 0);
    chk("underflow_pulse", int'(error_underflow), 1);
    step(0, 0, 8'h00, 0);
    step(0, 0, 8'h00, 1);

    // Full FIFO with simultaneous push and pop
    for (int i = 0; i < DEPTH; i++) step(1, 0, 8'hA0 + 8'(i), 0);
    for (int i = 0; i < 6; i++) step(1, 1, 8'hC0 + 8'(i), 0);
    for (int i = 0; i < DEPTH; i++) step(0, 1, 8'h00, 0);

    // Reset with five entries, then pop on empty
    for (int i = 0; i < 5; i++) step(1, 0, 8'h50 + 8'(i), 0);
    step(0, 0, 8'h00, 1);
    step(0, 1, 8'h00, 0);
    chk("pop_after_reset_underflow", int'(error_underflow), 1);
    step(0, 0, 8'h00, 1);

    // Randomized traffic with biased phases and runtime threshold changes
    pp = 50; qp = 50;
    for (int c = 0; c < 3000; c++) begin
      if (c % 100 == 0) begin
        pp = $urandom_range(90, 10);
        qp = $urandom_range(90, 10);
        umbral_almost_full  = 4'($urandom_range(15, 0));
        umbral_almost_empty = 4'($urandom_range(15, 0));
      end
      p = ($urandom_range(99, 0) < pp);
      q = ($urandom_range(99, 0) < qp);
      step(p, q, 8'($urandom), ($urandom_range(299, 0) == 0));
    end

    // Drain and confirm every expected word was delivered
    for (int i = 0; i < DEPTH + 1; i++) step(0, 1, 8'h00, 0);
    step(0, 0, 8'h00, 0);
    chk("scoreboard_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
